// File: rtl/sdc_axi_mem_bridge.sv
// sdc_axi_mem_bridge: AXI4 INCR burst slave serialising bursts into single-beat memory requests
module sdc_axi_mem_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic              s_axi_rlast,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT, RD_DATA} state_t;
  state_t state, state_n;
  logic last_wr, err, sel_wr, last_beat, w_beat;
  logic [ADDR_W-1:0] addr_cnt;
  logic [7:0] len, beat_cnt;
  always_comb begin
    sel_wr = s_axi_awvalid && !(s_axi_arvalid && last_wr);
    last_beat = beat_cnt == len;
    s_axi_awready = state == IDLE && sel_wr;
    s_axi_arready = state == IDLE && s_axi_arvalid && !sel_wr;
    s_axi_wready = state == WR_DATA && mem_gnt;
    w_beat = s_axi_wready && s_axi_wvalid;
    s_axi_bvalid = state == WR_RESP;
    s_axi_bresp = (s_axi_bvalid && err) ? 2'b10 : 2'b00;
    s_axi_rvalid = state == RD_DATA;
    s_axi_rlast = s_axi_rvalid && last_beat;
    mem_we = state == WR_DATA;
    mem_req = (mem_we && s_axi_wvalid) || state == RD_REQ;
    mem_addr = addr_cnt;
    mem_wdata = mem_we ? s_axi_wdata : '0;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = s_axi_awready ? WR_DATA : s_axi_arready ? RD_REQ : IDLE;
      WR_DATA: state_n = (w_beat && last_beat) ? WR_RESP : WR_DATA;
      WR_RESP: state_n = s_axi_bready ? IDLE : WR_RESP;
      RD_REQ:  state_n = mem_gnt ? RD_WAIT : RD_REQ;
      RD_WAIT: state_n = mem_rvalid ? RD_DATA : RD_WAIT;
      RD_DATA: state_n = s_axi_rready ? (last_beat ? IDLE : RD_REQ) : RD_DATA;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_wr <= 1'b0;
      addr_cnt <= '0;
      len <= '0;
      beat_cnt <= '0;
      err <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'b00;
    end else begin
      state <= state_n;
      if (s_axi_awready || s_axi_arready) begin
        addr_cnt <= s_axi_awready ? s_axi_awaddr : s_axi_araddr;
        len <= s_axi_awready ? s_axi_awlen : s_axi_arlen;
        beat_cnt <= '0;
        err <= 1'b0;
        last_wr <= s_axi_awready;
      end
      // a misplaced or missing wlast poisons the whole burst response
      if (w_beat) begin
        addr_cnt <= addr_cnt + STEP;
        beat_cnt <= beat_cnt + 8'd1;
        err <= err | mem_err | (s_axi_wlast != last_beat);
      end
      if (state == RD_WAIT && mem_rvalid) begin
        s_axi_rdata <= mem_rdata;
        s_axi_rresp <= mem_err ? 2'b10 : 2'b00;
      end
      if (state == RD_DATA && s_axi_rready && !last_beat) begin
        addr_cnt <= addr_cnt + STEP;
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_sdc_axi_mem_bridge.sv
// tb_sdc_axi_mem_bridge: randomized scoreboard bench with a memory responder and burst-level reference model
module tb_sdc_axi_mem_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0, s_axi_wdata = '0;
  logic [7:0] s_axi_awlen = '0, s_axi_arlen = '0;
  logic s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_wlast = 1'b0;
  logic s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast;
  logic s_axi_bready, s_axi_rready;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  always #5 clk = ~clk;
  sdc_axi_mem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );
  typedef struct { bit we; bit [31:0] a; bit [31:0] d; } op_t;
  typedef struct { bit [31:0] d; bit [1:0] resp; bit last; } r_t;
  typedef struct { bit [31:0] d; bit e; int due; } pend_t;
  typedef bit [31:0] dq_t[$];
  op_t exp_op[$];
  r_t exp_r[$];
  bit [1:0] exp_b[$];
  pend_t pend[$];
  bit [31:0] ref_mem[bit [31:0]];
  bit [31:0] phys[bit [31:0]];
  bit [31:0] err_addr = 32'h1;
  bit full_gnt = 1'b0, hold_rd = 1'b0, ref_last_wr = 1'b0;
  int n_cmp = 0, n_fail = 0, n_ops = 0, tcyc = 0, r_stall = 0;
  always @(posedge clk) tcyc <= tcyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tmo(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req && mem_gnt) begin
        if (mem_we) phys[mem_addr] = mem_wdata;
        else pend.push_back('{phys.exists(mem_addr) ? phys[mem_addr] : mem_addr ^ 32'hDEADBEEF,
                              mem_addr == err_addr, tcyc + 1 + int'($urandom_range(0, 2))});
      end
      @(posedge clk);
      #1;
      if (rst) pend.delete();
      mem_gnt = full_gnt || $urandom_range(0, 3) != 0;
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      mem_err = mem_we && mem_addr == err_addr;
      if (!hold_rd && pend.size() > 0 && pend[0].due <= tcyc) begin
        pend_t p;
        p = pend.pop_front();
        mem_rvalid = 1'b1;
        mem_rdata = p.d;
        mem_err = p.e;
      end
    end
  end
  initial begin
    s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (r_stall > 0 && s_axi_rvalid) begin
        s_axi_rready = 1'b0;
        r_stall--;
      end else s_axi_rready = $urandom_range(0, 3) != 0;
      s_axi_bready = $urandom_range(0, 2) != 0;
    end
  end
  always @(negedge clk) begin
    if (!rst && mem_req && mem_gnt) begin
      n_ops++;
      if (exp_op.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL op_extra: got op we=%0d addr=%0h, expected none", mem_we, mem_addr);
      end else begin
        op_t e;
        e = exp_op.pop_front();
        chk("op_we", mem_we, e.we);
        chk("op_addr", mem_addr, e.a);
        if (e.we) chk("op_wdata", mem_wdata, e.d);
      end
    end
    if (!rst && s_axi_bvalid && s_axi_bready) begin
      if (exp_b.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_extra: got bresp %0h, expected none", s_axi_bresp);
      end else chk("bresp", s_axi_bresp, exp_b.pop_front());
    end
    if (!rst && s_axi_rvalid && s_axi_rready) begin
      if (exp_r.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL r_extra: got rdata %0h, expected none", s_axi_rdata);
      end else begin
        r_t e;
        e = exp_r.pop_front();
        chk("rdata", s_axi_rdata, e.d);
        chk("rresp", s_axi_rresp, e.resp);
        chk("rlast", s_axi_rlast, e.last);
      end
    end
  end
  task automatic exp_write(input bit [31:0] a, input bit [7:0] l, input int lp, input dq_t d);
    bit e = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      bit [31:0] x;
      x = a + 32'(4 * i);
      exp_op.push_back('{1'b1, x, d[i]});
      ref_mem[x] = d[i];
      e = e | (x == err_addr) | ((i == lp) != (i == int'(l)));
    end
    exp_b.push_back(e ? 2'b10 : 2'b00);
    ref_last_wr = 1'b1;
  endtask
  task automatic exp_read(input bit [31:0] a, input bit [7:0] l);
    for (int i = 0; i <= int'(l); i++) begin
      bit [31:0] x;
      x = a + 32'(4 * i);
      exp_op.push_back('{1'b0, x, 32'h0});
      exp_r.push_back('{ref_mem.exists(x) ? ref_mem[x] : x ^ 32'hDEADBEEF, (x == err_addr) ? 2'b10 : 2'b00, i == int'(l)});
    end
    ref_last_wr = 1'b0;
  endtask
  task automatic drive_aw(input bit [31:0] a, input bit [7:0] l);
    s_axi_awaddr = a; s_axi_awlen = l; s_axi_awvalid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (s_axi_awready) break;
      if (t > 3000) begin tmo("aw_handshake"); break; end
    end
    @(posedge clk);
    #1 s_axi_awvalid = 1'b0;
  endtask
  task automatic drive_ar(input bit [31:0] a, input bit [7:0] l);
    s_axi_araddr = a; s_axi_arlen = l; s_axi_arvalid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (s_axi_arready) break;
      if (t > 3000) begin tmo("ar_handshake"); break; end
    end
    @(posedge clk);
    #1 s_axi_arvalid = 1'b0;
  endtask
  task automatic drive_w(input dq_t d, input bit [7:0] l, input int lp);
    for (int i = 0; i <= int'(l); i++) begin
      if (!full_gnt && $urandom_range(0, 3) == 0) begin
        s_axi_wvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      s_axi_wvalid = 1'b1; s_axi_wdata = d[i]; s_axi_wlast = i == lp;
      for (int t = 0; ; t++) begin
        @(negedge clk);
        if (s_axi_wready) break;
        if (t > 1000) begin tmo("w_handshake"); break; end
      end
      @(posedge clk);
      #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask
  task automatic wait_done(input string name);
    for (int t = 0; ; t++) begin
      @(posedge clk);
      if (exp_op.size() == 0 && exp_r.size() == 0 && exp_b.size() == 0) break;
      if (t > 5000) begin
        tmo(name);
        exp_op.delete(); exp_r.delete(); exp_b.delete();
        break;
      end
    end
    #1;
  endtask
  function automatic dq_t gen(input bit [7:0] l);
    dq_t d;
    for (int i = 0; i <= int'(l); i++) d.push_back($urandom);
    return d;
  endfunction
  task automatic do_write(input bit [31:0] a, input bit [7:0] l, input int lp);
    dq_t d;
    d = gen(l);
    exp_write(a, l, lp, d);
    drive_aw(a, l);
    drive_w(d, l, lp);
    wait_done("write_burst");
  endtask
  task automatic do_read(input bit [31:0] a, input bit [7:0] l);
    exp_read(a, l);
    drive_ar(a, l);
    wait_done("read_burst");
  endtask
  task automatic do_pair(input bit [31:0] wa, input bit [7:0] wl, input bit [31:0] ra, input bit [7:0] rl);
    dq_t d;
    d = gen(wl);
    if (!ref_last_wr) begin
      exp_write(wa, wl, int'(wl), d);
      exp_read(ra, rl);
    end else begin
      exp_read(ra, rl);
      exp_write(wa, wl, int'(wl), d);
    end
    fork
      begin drive_aw(wa, wl); drive_w(d, wl, int'(wl)); end
      drive_ar(ra, rl);
    join
    wait_done("pair");
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, s_axi_awready, 0);
    chk({tag, "_wready"}, s_axi_wready, 0);
    chk({tag, "_bvalid"}, s_axi_bvalid, 0);
    chk({tag, "_bresp"}, s_axi_bresp, 0);
    chk({tag, "_rvalid"}, s_axi_rvalid, 0);
    chk({tag, "_rdata"}, s_axi_rdata, 0);
    chk({tag, "_rresp"}, s_axi_rresp, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
  endtask
  initial begin
    int c0, target;
    dq_t d;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    do_pair(32'h400, 8'd2, 32'h500, 8'd1);
    do_write(32'h600, 8'd0, 0);
    do_pair(32'h700, 8'd1, 32'h400, 8'd2);
    full_gnt = 1'b1;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_wready", s_axi_wready, 0);
      chk("idle_mem_req", mem_req, 0);
    end
    @(posedge clk);
    #1 s_axi_wvalid = 1'b0;
    d = gen(8'd3);
    exp_write(32'h100, 8'd3, 3, d);
    drive_aw(32'h100, 8'd3);
    c0 = tcyc;
    drive_w(d, 8'd3, 3);
    chk("t1_beat_cycles", tcyc - c0, 4);
    chk("t1_bvalid_next", s_axi_bvalid, 1);
    wait_done("t1");
    full_gnt = 1'b0;
    r_stall = 3;
    do_read(32'h200, 8'd1);
    do_read(32'h100, 8'd3);
    do_write(32'h300, 8'd3, 2);
    do_write(32'h340, 8'd3, 9);
    err_addr = 32'h304;
    do_read(32'h300, 8'd2);
    err_addr = 32'h344;
    do_write(32'h340, 8'd1, 1);
    err_addr = 32'h1;
    do_write(32'hFFFFFFFC, 8'd1, 1);
    do_read(32'hFFFFFFFC, 8'd1);
    for (int n = 0; n < 40; n++) begin
      bit [31:0] a, b;
      bit [7:0] l, m;
      int lp;
      a = 32'h1000 + 32'(4 * $urandom_range(0, 127));
      b = 32'h1000 + 32'(4 * $urandom_range(0, 127));
      l = 8'($urandom_range(0, 7));
      m = 8'($urandom_range(0, 7));
      lp = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 8)) : int'(l);
      err_addr = ($urandom_range(0, 3) == 0) ? a + 32'(4 * $urandom_range(0, 7)) : 32'h1;
      case ($urandom_range(0, 2))
        0: do_write(a, l, lp);
        1: do_read(a, l);
        default: do_pair(a, l, b, m);
      endcase
    end
    err_addr = 32'h1;
    do_write(32'h2000, 8'd255, 255);
    do_read(32'h2000, 8'd255);
    hold_rd = 1'b1;
    target = n_ops + 1;
    exp_op.push_back('{1'b0, 32'h800, 32'h0});
    drive_ar(32'h800, 8'd2);
    for (int t = 0; ; t++) begin
      @(posedge clk);
      if (n_ops >= target) break;
      if (t > 500) begin tmo("t6_read_grant"); break; end
    end
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("t6");
    chk("t6_arready", s_axi_arready, 0);
    rst = 1'b0;
    hold_rd = 1'b0;
    ref_last_wr = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_rvalid", s_axi_rvalid, 0);
    chk("t6_no_bvalid", s_axi_bvalid, 0);
    @(posedge clk);
    #1;
    do_read(32'h800, 8'd2);
    do_pair(32'h900, 8'd1, 32'h100, 8'd1);
    repeat (5) @(posedge clk);
    chk("final_queues_empty", exp_op.size() + exp_r.size() + exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
